// File: rtl/bnn_conv1d_engine.sv
// bnn_conv1d_engine
//   1-D convolution engine: NUM_KERNELS kernels of TAPS taps applied to each
//   incoming window of TAPS signed samples. Two register stages: per-tap
//   products, then per-kernel sum saturated to ACC_W bits.
// Ports
//   clk, rst         clock; asynchronous active-high reset
//   wt_wr_*          weight write port (out-of-range indices ignored)
//   frame_clr        restarts the frame index at the next accepted window
//   in_valid/ready   input window handshake, data_in tap t at [t*DATA_W +: DATA_W]
//   out_valid/ready  result handshake, conv_out kernel k at [k*ACC_W +: ACC_W]
//   out_frame        frame index carried with conv_out
//   conv_done        high with the result of frame FRAMES-1
module bnn_conv1d_engine #(
  parameter  int DATA_W      = 16,
  parameter  int ACC_W       = 32,
  parameter  int TAPS        = 5,
  parameter  int NUM_KERNELS = 3,
  parameter  int FRAMES      = 36,
  parameter  int BIN_WEIGHTS = 0,
  localparam int KW = (NUM_KERNELS > 1) ? $clog2(NUM_KERNELS) : 1,
  localparam int TW = (TAPS > 1) ? $clog2(TAPS) : 1,
  localparam int FW = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wt_wr_en,
  input  logic [KW-1:0]                 wt_wr_kernel,
  input  logic [TW-1:0]                 wt_wr_tap,
  input  logic [DATA_W-1:0]             wt_wr_data,
  input  logic                          frame_clr,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [TAPS*DATA_W-1:0]        data_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_KERNELS*ACC_W-1:0]  conv_out,
  output logic [FW-1:0]                 out_frame,
  output logic                          conv_done
);

  localparam int PW = 2 * DATA_W;
  localparam int SW = PW + $clog2(TAPS);
  localparam int WB = (BIN_WEIGHTS != 0) ? 1 : DATA_W;

  logic [WB-1:0]                  wt_mem    [NUM_KERNELS][TAPS];
  logic signed [PW-1:0]           prod_next [NUM_KERNELS][TAPS];
  logic signed [PW-1:0]           s1_prod   [NUM_KERNELS][TAPS];
  logic                           s1_valid;
  logic [FW-1:0]                  s1_frame;
  logic [FW-1:0]                  frame_cnt;
  logic [FW-1:0]                  frame_base;
  logic [NUM_KERNELS*ACC_W-1:0]   res_next;
  logic                           advance;
  logic                           in_xfer;

  // Output stage may load when empty or being drained; stage 1 may load when
  // it is empty or moving into stage 2, which is exactly in_ready.
  assign advance    = !out_valid || out_ready;
  assign in_ready   = !(s1_valid && out_valid && !out_ready);
  assign in_xfer    = in_valid && in_ready;
  assign frame_base = frame_clr ? '0 : frame_cnt;

  // Weight store: written registers are only seen by windows accepted later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < NUM_KERNELS; k++)
        for (int unsigned t = 0; t < TAPS; t++)
          wt_mem[k][t] <= '0;
    end else if (wt_wr_en) begin
      for (int unsigned k = 0; k < NUM_KERNELS; k++)
        for (int unsigned t = 0; t < TAPS; t++)
          if (wt_wr_kernel == KW'(k) && wt_wr_tap == TW'(t))
            wt_mem[k][t] <= wt_wr_data[WB-1:0];
    end
  end

  if (BIN_WEIGHTS != 0) begin : g_bin
    // Stored bit 1 means +1, 0 means -1.
    always_comb begin
      for (int unsigned k = 0; k < NUM_KERNELS; k++)
        for (int unsigned t = 0; t < TAPS; t++)
          prod_next[k][t] = wt_mem[k][t][0]
                          ?  PW'($signed(data_in[t*DATA_W +: DATA_W]))
                          : -PW'($signed(data_in[t*DATA_W +: DATA_W]));
    end
  end else begin : g_mul
    always_comb begin
      for (int unsigned k = 0; k < NUM_KERNELS; k++)
        for (int unsigned t = 0; t < TAPS; t++)
          prod_next[k][t] = PW'($signed(data_in[t*DATA_W +: DATA_W]))
                          * PW'($signed(wt_mem[k][t]));
    end
  end

  for (genvar gk = 0; gk < NUM_KERNELS; gk++) begin : g_sum
    logic signed [SW-1:0] sum;

    always_comb begin
      sum = '0;
      for (int unsigned t = 0; t < TAPS; t++)
        sum = sum + SW'(s1_prod[gk][t]);
    end

    if (SW > ACC_W) begin : g_sat
      localparam logic signed [SW-1:0] SAT_MAX = {{(SW-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
      localparam logic signed [SW-1:0] SAT_MIN = {{(SW-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};
      assign res_next[gk*ACC_W +: ACC_W] =
          (sum > SAT_MAX) ? {1'b0, {(ACC_W-1){1'b1}}} :
          (sum < SAT_MIN) ? {1'b1, {(ACC_W-1){1'b0}}} :
                            sum[ACC_W-1:0];
    end else begin : g_ext
      assign res_next[gk*ACC_W +: ACC_W] = ACC_W'(sum);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
      s1_valid  <= 1'b0;
      s1_frame  <= '0;
      for (int unsigned k = 0; k < NUM_KERNELS; k++)
        for (int unsigned t = 0; t < TAPS; t++)
          s1_prod[k][t] <= '0;
      out_valid <= 1'b0;
      conv_out  <= '0;
      out_frame <= '0;
      conv_done <= 1'b0;
    end else begin
      // A clear coinciding with an accept gives that window index 0.
      if (in_xfer)
        frame_cnt <= (frame_base == FW'(FRAMES-1)) ? '0 : frame_base + FW'(1);
      else if (frame_clr)
        frame_cnt <= '0;

      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_prod  <= prod_next;
          s1_frame <= frame_base;
        end
      end

      if (advance) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          conv_out  <= res_next;
          out_frame <= s1_frame;
          conv_done <= (s1_frame == FW'(FRAMES-1));
        end else begin
          conv_done <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_bnn_conv1d_engine.sv
// Directed bench for bnn_conv1d_engine: a multi-bit-weight instance and a
// binary-weight instance share clock and reset.
module tb_bnn_conv1d_engine;

  logic        clk;
  logic        rst;

  logic        wt_wr_en;
  logic [1:0]  wt_wr_kernel;
  logic [2:0]  wt_wr_tap;
  logic [15:0] wt_wr_data;
  logic        frame_clr;
  logic        in_valid;
  logic        in_ready;
  logic [79:0] data_in;
  logic        out_valid;
  logic        out_ready;
  logic [95:0] conv_out;
  logic [5:0]  out_frame;
  logic        conv_done;

  logic        b_wt_wr_en;
  logic [1:0]  b_wt_wr_kernel;
  logic [2:0]  b_wt_wr_tap;
  logic [15:0] b_wt_wr_data;
  logic        b_frame_clr;
  logic        b_in_valid;
  logic        b_in_ready;
  logic [79:0] b_data_in;
  logic        b_out_valid;
  logic        b_out_ready;
  logic [95:0] b_conv_out;
  logic [5:0]  b_out_frame;
  logic        b_conv_done;

  int passed = 0;
  int total  = 0;

  bnn_conv1d_engine dut (
    .clk(clk), .rst(rst),
    .wt_wr_en(wt_wr_en), .wt_wr_kernel(wt_wr_kernel), .wt_wr_tap(wt_wr_tap),
    .wt_wr_data(wt_wr_data), .frame_clr(frame_clr),
    .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
    .out_valid(out_valid), .out_ready(out_ready), .conv_out(conv_out),
    .out_frame(out_frame), .conv_done(conv_done)
  );

  bnn_conv1d_engine #(.BIN_WEIGHTS(1)) b_dut (
    .clk(clk), .rst(rst),
    .wt_wr_en(b_wt_wr_en), .wt_wr_kernel(b_wt_wr_kernel), .wt_wr_tap(b_wt_wr_tap),
    .wt_wr_data(b_wt_wr_data), .frame_clr(b_frame_clr),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .data_in(b_data_in),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .conv_out(b_conv_out),
    .out_frame(b_out_frame), .conv_done(b_conv_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [79:0] win5(input int a, input int b, input int c,
                                       input int d, input int e);
    return {e[15:0], d[15:0], c[15:0], b[15:0], a[15:0]};
  endfunction

  function automatic logic [95:0] res3(input logic [31:0] k0, input logic [31:0] k1,
                                       input logic [31:0] k2);
    return {k2, k1, k0};
  endfunction

  task automatic write_w(input int k, input int t, input logic [15:0] v);
    @(negedge clk);
    wt_wr_en = 1'b1; wt_wr_kernel = k[1:0]; wt_wr_tap = t[2:0]; wt_wr_data = v;
    @(posedge clk); #1;
    wt_wr_en = 1'b0;
  endtask

  task automatic write_bw(input int k, input int t, input logic [15:0] v);
    @(negedge clk);
    b_wt_wr_en = 1'b1; b_wt_wr_kernel = k[1:0]; b_wt_wr_tap = t[2:0]; b_wt_wr_data = v;
    @(posedge clk); #1;
    b_wt_wr_en = 1'b0;
  endtask

  task automatic load_legacy();
    for (int k = 0; k < 3; k++)
      for (int t = 0; t < 5; t++)
        write_w(k, t, 16'(k + 1));
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    in_valid = 1'b0; frame_clr = 1'b1;
    @(posedge clk); #1;
    frame_clr = 1'b0;
  endtask

  // Presents one window and waits (bounded) for its result.
  task automatic run_window(input logic [79:0] w, output logic [95:0] res,
                            output logic [5:0] frm, output logic ok);
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; data_in = w;
    @(posedge clk); #1;
    in_valid = 1'b0;
    ok = 1'b0; res = '0; frm = '0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk); #1;
      if (out_valid) begin
        ok = 1'b1; res = conv_out; frm = out_frame;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passed++;
    total++; if (conv_out !== 96'h0) $display("FAIL reset_conv_out: got %h want 0", conv_out); else passed++;
    total++; if (out_frame !== 6'd0) $display("FAIL reset_out_frame: got %0d want 0", out_frame); else passed++;
    total++; if (conv_done !== 1'b0) $display("FAIL reset_conv_done: got %b want 0", conv_done); else passed++;
    total++; if (b_out_valid !== 1'b0) $display("FAIL reset_bin_out_valid: got %b want 0", b_out_valid); else passed++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_legacy();
    load_legacy();
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; data_in = win5(1, 2, 3, 4, 5);
    @(negedge clk);
    in_valid = 1'b0; #1;
    total++; if (out_valid !== 1'b0) $display("FAIL legacy_early_valid: got %b want 0", out_valid); else passed++;
    @(negedge clk); #1;
    total++; if (out_valid !== 1'b1) $display("FAIL legacy_valid: got %b want 1", out_valid); else passed++;
    total++; if (conv_out !== res3(15, 30, 45)) $display("FAIL legacy_conv_out: got %h want %h", conv_out, res3(15, 30, 45)); else passed++;
    total++; if (out_frame !== 6'd0) $display("FAIL legacy_frame: got %0d want 0", out_frame); else passed++;
    total++; if (conv_done !== 1'b0) $display("FAIL legacy_done: got %b want 0", conv_done); else passed++;
    @(negedge clk); #1;
    total++; if (out_valid !== 1'b0) $display("FAIL legacy_no_dup: got %b want 0", out_valid); else passed++;
  endtask

  task automatic test_saturation();
    logic [95:0] res;
    logic [5:0]  frm;
    logic        ok;
    for (int k = 0; k < 3; k++)
      for (int t = 0; t < 5; t++)
        write_w(k, t, 16'h7FFF);
    run_window(win5(32'h7FFF, 32'h7FFF, 32'h7FFF, 32'h7FFF, 32'h7FFF), res, frm, ok);
    total++; if (ok !== 1'b1) $display("FAIL sat_pos_timeout: got %b want 1", ok); else passed++;
    total++; if (res !== res3(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF)) $display("FAIL sat_pos: got %h want 7fffffff x3", res); else passed++;
    run_window(win5(32'h8000, 32'h8000, 32'h8000, 32'h8000, 32'h8000), res, frm, ok);
    total++; if (ok !== 1'b1) $display("FAIL sat_neg_timeout: got %b want 1", ok); else passed++;
    total++; if (res !== res3(32'h80000000, 32'h80000000, 32'h80000000)) $display("FAIL sat_neg: got %h want 80000000 x3", res); else passed++;
    write_w(0, 0, 16'd2);
    run_window(win5(-3, 0, 0, 0, 0), res, frm, ok);
    total++; if (ok !== 1'b1) $display("FAIL neg_small_timeout: got %b want 1", ok); else passed++;
    total++; if (res[31:0] !== 32'hFFFFFFFA) $display("FAIL neg_small_k0: got %h want fffffffa", res[31:0]); else passed++;
    total++; if (res[63:32] !== 32'hFFFE8003) $display("FAIL neg_small_k1: got %h want fffe8003", res[63:32]); else passed++;
  endtask

  task automatic test_binary();
    logic ok;
    write_bw(0, 0, 16'd1); write_bw(0, 1, 16'd0); write_bw(0, 2, 16'd1);
    write_bw(0, 3, 16'd0); write_bw(0, 4, 16'hFFFF);
    @(negedge clk);
    b_out_ready = 1'b1; b_in_valid = 1'b1; b_data_in = win5(10, 20, 30, 40, 50);
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk); #1;
      if (b_out_valid) begin
        ok = 1'b1;
        total++; if (b_conv_out[31:0] !== 32'd30) $display("FAIL bin_k0: got %0d want 30", $signed(b_conv_out[31:0])); else passed++;
        total++; if (b_conv_out[63:32] !== 32'hFFFFFF6A) $display("FAIL bin_k1: got %h want ffffff6a", b_conv_out[63:32]); else passed++;
        total++; if (b_conv_out[95:64] !== 32'hFFFFFF6A) $display("FAIL bin_k2: got %h want ffffff6a", b_conv_out[95:64]); else passed++;
      end
    end
    total++; if (ok !== 1'b1) $display("FAIL bin_timeout: got %b want 1", ok); else passed++;
  endtask

  task automatic test_backpressure();
    int          acc, got, occ;
    logic        held, saw_low, ix, ox, exp_rdy;
    logic [95:0] prev_out, want;
    logic [5:0]  prev_frm;
    load_legacy();
    pulse_clr();
    acc = 0; got = 0; occ = 0; held = 1'b0; saw_low = 1'b0;
    prev_out = '0; prev_frm = '0;
    for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
      @(negedge clk);
      out_ready = (cyc % 3 == 0);
      in_valid  = (acc < 6);
      data_in   = win5(acc + 1, acc + 1, acc + 1, acc + 1, acc + 1);
      #1;
      exp_rdy = !(occ == 2 && !out_ready);
      total++; if (in_ready !== exp_rdy) $display("FAIL bp_in_ready cyc%0d: got %b want %b", cyc, in_ready, exp_rdy); else passed++;
      if (!in_ready) saw_low = 1'b1;
      if (held) begin
        total++; if (out_valid !== 1'b1 || conv_out !== prev_out || out_frame !== prev_frm)
          $display("FAIL bp_stable cyc%0d: got %b/%h/%0d want 1/%h/%0d", cyc, out_valid, conv_out, out_frame, prev_out, prev_frm);
        else passed++;
      end
      ox = out_valid && out_ready;
      ix = in_valid && in_ready;
      if (ox) begin
        want = res3(5 * (got + 1), 10 * (got + 1), 15 * (got + 1));
        total++; if (conv_out !== want) $display("FAIL bp_data #%0d: got %h want %h", got, conv_out, want); else passed++;
        total++; if (out_frame !== 6'(got)) $display("FAIL bp_frame #%0d: got %0d want %0d", got, out_frame, got); else passed++;
        got++;
      end
      held = out_valid && !out_ready;
      prev_out = conv_out; prev_frm = out_frame;
      if (ix) acc++;
      occ = occ + (ix ? 1 : 0) - (ox ? 1 : 0);
    end
    total++; if (got !== 6) $display("FAIL bp_count: got %0d want 6", got); else passed++;
    total++; if (saw_low !== 1'b1) $display("FAIL bp_ready_fell: got %b want 1", saw_low); else passed++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1; #1;
      total++; if (out_valid !== 1'b0) $display("FAIL bp_extra_result %0d: got %b want 0", i, out_valid); else passed++;
    end
  endtask

  task automatic test_frame_wrap();
    int sent, got;
    int exp_f[5] = '{1, 2, 0, 1, 2};
    pulse_clr();
    sent = 0; got = 0;
    for (int cyc = 0; cyc < 80 && got < 37; cyc++) begin
      @(negedge clk);
      out_ready = 1'b1; in_valid = (sent < 37); data_in = win5(1, 1, 1, 1, 1);
      #1;
      if (out_valid) begin
        total++; if (out_frame !== 6'(got % 36)) $display("FAIL wrap_frame #%0d: got %0d want %0d", got, out_frame, got % 36); else passed++;
        total++; if (conv_done !== (got % 36 == 35)) $display("FAIL wrap_done #%0d: got %b want %b", got, conv_done, (got % 36 == 35)); else passed++;
        got++;
      end
      if (in_valid && in_ready) sent++;
    end
    total++; if (got !== 37) $display("FAIL wrap_count: got %0d want 37", got); else passed++;

    sent = 0; got = 0;
    for (int cyc = 0; cyc < 20 && got < 5; cyc++) begin
      @(negedge clk);
      out_ready = 1'b1; in_valid = (sent < 5); data_in = win5(1, 1, 1, 1, 1);
      frame_clr = (sent == 2);
      #1;
      if (out_valid) begin
        total++; if (out_frame !== 6'(exp_f[got])) $display("FAIL clr_frame #%0d: got %0d want %0d", got, out_frame, exp_f[got]); else passed++;
        got++;
      end
      if (in_valid && in_ready) sent++;
    end
    frame_clr = 1'b0;
    total++; if (got !== 5) $display("FAIL clr_count: got %0d want 5", got); else passed++;
  endtask

  task automatic test_weight_race();
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; data_in = win5(1, 1, 1, 1, 1);
    wt_wr_en = 1'b1; wt_wr_kernel = 2'd0; wt_wr_tap = 3'd0; wt_wr_data = 16'd100;
    @(negedge clk);
    wt_wr_en = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; #1;
    total++; if (out_valid !== 1'b1 || conv_out[31:0] !== 32'd5) $display("FAIL race_old_weight: got %b/%0d want 1/5", out_valid, conv_out[31:0]); else passed++;
    @(negedge clk); #1;
    total++; if (out_valid !== 1'b1 || conv_out[31:0] !== 32'd104) $display("FAIL race_new_weight: got %b/%0d want 1/104", out_valid, conv_out[31:0]); else passed++;
    total++; if (conv_out[63:32] !== 32'd10) $display("FAIL race_k1: got %0d want 10", conv_out[63:32]); else passed++;
  endtask

  task automatic test_reset_inflight();
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; data_in = win5(2, 2, 2, 2, 2);
    @(negedge clk);
    data_in = win5(3, 3, 3, 3, 3);
    @(negedge clk);
    in_valid = 1'b0; #1;
    total++; if (in_ready !== 1'b0) $display("FAIL inflight_full: got %b want 0", in_ready); else passed++;
    rst = 1'b1; #1;
    total++; if (out_valid !== 1'b0) $display("FAIL rst_async_valid: got %b want 0", out_valid); else passed++;
    total++; if (conv_out !== 96'h0) $display("FAIL rst_async_data: got %h want 0", conv_out); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL rst_async_ready: got %b want 1", in_ready); else passed++;
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      total++; if (out_valid !== 1'b0) $display("FAIL rst_nothing_emerges %0d: got %b want 0", i, out_valid); else passed++;
    end
  endtask

  initial begin
    rst = 1'b1;
    wt_wr_en = 1'b0; wt_wr_kernel = '0; wt_wr_tap = '0; wt_wr_data = '0;
    frame_clr = 1'b0; in_valid = 1'b0; data_in = '0; out_ready = 1'b0;
    b_wt_wr_en = 1'b0; b_wt_wr_kernel = '0; b_wt_wr_tap = '0; b_wt_wr_data = '0;
    b_frame_clr = 1'b0; b_in_valid = 1'b0; b_data_in = '0; b_out_ready = 1'b1;

    test_reset();
    test_legacy();
    test_saturation();
    test_binary();
    test_backpressure();
    test_frame_wrap();
    test_weight_race();
    test_reset_inflight();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
